// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the system ID (word 0)
// and build timestamp (word 1) from the sysid slave, compares both against
// the expected image values and publishes captured words plus pass/fail flags.
// Optional feature macro: SYSID_CHECK_PERIODIC_EN (auto-check after reset and
// periodic re-check every RECHECK_CYCLES idle cycles).
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd170,
  parameter logic [31:0] EXPECTED_TS    = 32'd1603623072,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned RECHECK_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        match,
  output logic        fail_sticky
);

  // Latencies above 3 do not fit the 2-bit hold counter, so they saturate.
  localparam int unsigned LAT_SAT = (READ_LATENCY > 3) ? 3 : READ_LATENCY;
  localparam logic [1:0]  LAT     = LAT_SAT[1:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  holdCnt_q, holdCnt_d;
  logic [31:0] idCapture_q, idCapture_d;
  logic [31:0] idValue_q, idValue_d;
  logic [31:0] tsValue_q, tsValue_d;
  logic        idOk_q, idOk_d;
  logic        tsOk_q, tsOk_d;
  logic        match_q, match_d;
  logic        failSticky_q, failSticky_d;
  logic        startReq;
  logic        idMatches;
  logic        tsMatches;

`ifdef SYSID_CHECK_PERIODIC_EN
  localparam logic [31:0] RECHECK = RECHECK_CYCLES[31:0];

  logic [31:0] idleCnt_q, idleCnt_d;
  logic        kick_q;

  // One-shot flag that requests a check on the first cycle after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kick_q <= 1'b1;
    end else begin
      kick_q <= 1'b0;
    end
  end

  // A check may come from the requester, the post-reset kick or the idle timer.
  always_comb begin
    startReq = start | kick_q | (idleCnt_q == RECHECK);
  end

  // Idle timer runs only in IDLE and restarts whenever a check is launched.
  always_comb begin
    idleCnt_d = 32'd0;
    if (state_q == IDLE && !startReq) begin
      idleCnt_d = idleCnt_q + 32'd1;
    end
  end

  // Idle timer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idleCnt_q <= 32'd0;
    end else begin
      idleCnt_q <= idleCnt_d;
    end
  end
`else
  logic unusedRecheck;

  // Without the periodic feature only the external request launches a check.
  always_comb begin
    startReq = start;
  end

  assign unusedRecheck = |RECHECK_CYCLES;
`endif

  // Full 32-bit comparisons of the words that will be published together.
  always_comb begin
    idMatches = (idCapture_q == EXPECTED_ID);
    tsMatches = (sid_readdata == EXPECTED_TS);
  end

  // Next-state, hold counter, capture and bus/status outputs for the read sequence.
  always_comb begin
    state_d      = state_q;
    holdCnt_d    = holdCnt_q;
    idCapture_d  = idCapture_q;
    idValue_d    = idValue_q;
    tsValue_d    = tsValue_q;
    idOk_d       = idOk_q;
    tsOk_d       = tsOk_q;
    match_d      = match_q;
    failSticky_d = failSticky_q;
    sid_address  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (startReq) begin
          holdCnt_d = LAT;
          state_d   = RD_ID;
        end
      end
      RD_ID: begin
        busy = 1'b1;
        if (holdCnt_q != 2'd0) begin
          holdCnt_d = holdCnt_q - 2'd1;
        end else begin
          idCapture_d = sid_readdata;
          holdCnt_d   = LAT;
          state_d     = RD_TS;
        end
      end
      RD_TS: begin
        sid_address = 1'b1;
        busy        = 1'b1;
        if (holdCnt_q != 2'd0) begin
          holdCnt_d = holdCnt_q - 2'd1;
        end else begin
          idValue_d = idCapture_q;
          tsValue_d = sid_readdata;
          idOk_d    = idMatches;
          tsOk_d    = tsMatches;
          match_d   = idMatches & tsMatches;
          if (!(idMatches & tsMatches)) begin
            failSticky_d = 1'b1;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and result registers; reset aborts any check in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      holdCnt_q    <= 2'd0;
      idCapture_q  <= 32'd0;
      idValue_q    <= 32'd0;
      tsValue_q    <= 32'd0;
      idOk_q       <= 1'b0;
      tsOk_q       <= 1'b0;
      match_q      <= 1'b0;
      failSticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      holdCnt_q    <= holdCnt_d;
      idCapture_q  <= idCapture_d;
      idValue_q    <= idValue_d;
      tsValue_q    <= tsValue_d;
      idOk_q       <= idOk_d;
      tsOk_q       <= tsOk_d;
      match_q      <= match_d;
      failSticky_q <= failSticky_d;
    end
  end

  assign id_value    = idValue_q;
  assign ts_value    = tsValue_q;
  assign id_ok       = idOk_q;
  assign ts_ok       = tsOk_q;
  assign match       = match_q;
  assign fail_sticky = failSticky_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Testbench for sysid_checker: three instances with READ_LATENCY 0, 1 and 2
// share clock, reset and start; each has its own sysid slave model.
module tb_sysid_checker;

  localparam logic [31:0] GOOD_ID = 32'd170;
  localparam logic [31:0] GOOD_TS = 32'd1603623072;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] idWord;
  logic [31:0] tsWord;
  bit          glitch [3];

  logic        sidAddress [3];
  logic [31:0] rdata [3];
  logic        busy [3];
  logic        done [3];
  logic [31:0] idValue [3];
  logic [31:0] tsValue [3];
  logic        idOk [3];
  logic        tsOk [3];
  logic        matchO [3];
  logic        failSticky [3];

  // Reference model: results each instance should currently publish.
  logic [31:0] expId [3];
  logic [31:0] expTs [3];
  logic        expIdOk [3];
  logic        expTsOk [3];
  logic        expMatch [3];
  logic        expSticky [3];

  int errors = 0;
  int checks = 0;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  for (genvar g = 0; g < 3; g++) begin : gDut
    // Sysid slave: word select picks ID or timestamp; glitch inverts the word.
    assign rdata[g] = glitch[g] ? ~(sidAddress[g] ? tsWord : idWord)
                                : (sidAddress[g] ? tsWord : idWord);

    sysid_checker #(
      .EXPECTED_ID(GOOD_ID),
      .EXPECTED_TS(GOOD_TS),
      .READ_LATENCY(g),
      .RECHECK_CYCLES(10)
    ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .sid_address(sidAddress[g]),
      .sid_readdata(rdata[g]),
      .busy(busy[g]),
      .done(done[g]),
      .id_value(idValue[g]),
      .ts_value(tsValue[g]),
      .id_ok(idOk[g]),
      .ts_ok(tsOk[g]),
      .match(matchO[g]),
      .fail_sticky(failSticky[g])
    );
  end

  task automatic checkVal(input string tag, input int g, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s dut%0d: observed %0h expected %0h", tag, g, obs, exp);
    end
  endtask

  task automatic checkOutput(input int g, input logic busyE, input logic doneE,
                             input logic addrE);
    checkVal("busy", g, {31'd0, busy[g]}, {31'd0, busyE});
    checkVal("done", g, {31'd0, done[g]}, {31'd0, doneE});
    checkVal("sid_address", g, {31'd0, sidAddress[g]}, {31'd0, addrE});
    checkVal("id_value", g, idValue[g], expId[g]);
    checkVal("ts_value", g, tsValue[g], expTs[g]);
    checkVal("id_ok", g, {31'd0, idOk[g]}, {31'd0, expIdOk[g]});
    checkVal("ts_ok", g, {31'd0, tsOk[g]}, {31'd0, expTsOk[g]});
    checkVal("match", g, {31'd0, matchO[g]}, {31'd0, expMatch[g]});
    checkVal("fail_sticky", g, {31'd0, failSticky[g]}, {31'd0, expSticky[g]});
  endtask

  task automatic clearModel();
    for (int g = 0; g < 3; g++) begin
      expId[g]     = 32'd0;
      expTs[g]     = 32'd0;
      expIdOk[g]   = 1'b0;
      expTsOk[g]   = 1'b0;
      expMatch[g]  = 1'b0;
      expSticky[g] = 1'b0;
    end
  endtask

  // One check: start in cycle 0, optional dropped re-starts in cycles 1..3,
  // optional glitch on the unsampled first held cycle of the L=1 instance.
  task automatic applyStimulus(input logic [31:0] idW, input logic [31:0] tsW,
                               input bit restarts, input bit doGlitch);
    int lat;
    @(posedge clock); #1;
    idWord = idW;
    tsWord = tsW;
    start  = 1'b1;
    @(negedge clock);
    for (int g = 0; g < 3; g++) checkOutput(g, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock); #1;
      start     = restarts && (k <= 3);
      glitch[1] = doGlitch && (k == 1 || k == 3);
      @(negedge clock);
      for (int g = 0; g < 3; g++) begin
        lat = g;
        if (k == 2 * lat + 3) begin
          expId[g]     = idW;
          expTs[g]     = tsW;
          expIdOk[g]   = (idW == GOOD_ID);
          expTsOk[g]   = (tsW == GOOD_TS);
          expMatch[g]  = (idW == GOOD_ID) && (tsW == GOOD_TS);
          expSticky[g] = expSticky[g] || !expMatch[g];
        end
        checkOutput(g, k <= 2 * lat + 2, k == 2 * lat + 3,
                    (k >= lat + 2) && (k <= 2 * lat + 2));
      end
    end
  endtask

  initial begin
    logic [31:0] rId;
    logic [31:0] rTs;
    start  = 1'b0;
    reset  = 1'b1;
    idWord = GOOD_ID;
    tsWord = GOOD_TS;
    for (int g = 0; g < 3; g++) glitch[g] = 1'b0;
    clearModel();

    $display("[TB] reset state");
    #12;
    for (int g = 0; g < 3; g++) checkOutput(g, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;

    $display("[TB] good image");
    applyStimulus(GOOD_ID, GOOD_TS, 1'b0, 1'b0);

    $display("[TB] bad timestamp, then good check keeps sticky");
    applyStimulus(GOOD_ID, 32'h5F9A_0001, 1'b0, 1'b0);
    applyStimulus(GOOD_ID, GOOD_TS, 1'b0, 1'b0);

    $display("[TB] start re-asserted while running");
    applyStimulus(32'h0000_00AB, GOOD_TS, 1'b1, 1'b0);

    $display("[TB] reset in cycle 2 of a check");
    @(posedge clock); #1;
    idWord = 32'h1234_5678;
    tsWord = GOOD_TS;
    start  = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #3;
    reset = 1'b1;
    clearModel();
    #1;
    for (int g = 0; g < 3; g++) checkOutput(g, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      for (int g = 0; g < 3; g++) checkOutput(g, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(GOOD_ID, GOOD_TS, 1'b0, 1'b0);

    $display("[TB] glitch on unsampled cycle");
    applyStimulus(GOOD_ID, GOOD_TS, 1'b0, 1'b1);

    $display("[TB] randomized checks");
    for (int n = 0; n < 12; n++) begin
      rId = ($urandom_range(0, 1) == 1) ? GOOD_ID : $urandom;
      rTs = ($urandom_range(0, 1) == 1) ? GOOD_TS : $urandom;
      applyStimulus(rId, rTs, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
